// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_scheduler
//  Purpose  : Round-robin front end that shares one UART transmitter among
//             N_REQ byte requesters. It launches one frame at a time and,
//             because the transmitter reports no completion, it counts
//             baud_clk_en pulses to learn when the frame (and an optional
//             idle gap) has finished.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   clock
//    rst_n          in   asynchronous active-low reset (shared with the UART)
//    baud_clk_en    in   single-cycle baud pulse, same one the UART uses
//    req_valid      in   [N_REQ]   requester i has a byte pending
//    req_data       in   [8*N_REQ] byte of requester i at [8i+7:8i]
//    req_ready      out  [N_REQ]   one-hot accept, combinational
//    tx_data        out  [8]       byte to the UART, registered
//    tx_start_send  out            start pulse to the UART, registered
//    grant_id       out  [ID_W]    owner of the current / latest frame
//    busy           out            scheduler not idle
//    frame_done     out            one-cycle pulse when a frame completes
// ============================================================================
module uart_tx_scheduler #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int FRAME_TICKS = 11,
  parameter int GAP_TICKS   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_clk_en,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start_send,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_LAUNCH = 2'd1;
  localparam logic [1:0] C_FRAME  = 2'd2;
  localparam logic [1:0] C_GAP    = 2'd3;

  localparam logic [7:0]      C_FRAME_LAST = 8'(FRAME_TICKS - 1);
  // With no gap configured this value is never compared against.
  localparam logic [7:0]      C_GAP_LAST   = 8'(GAP_TICKS - 1);
  localparam bit              C_HAS_GAP    = (GAP_TICKS > 0);
  localparam logic [ID_W-1:0] C_LAST_ID    = ID_W'(N_REQ - 1);

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic            frame_done_q, frame_done_d;

  logic            w_hi_found, w_lo_found;
  logic [ID_W-1:0] w_hi_idx, w_lo_idx, w_win_idx;
  logic            w_accept;
  logic            w_frame_last;
  logic            w_gap_last;

  // Round-robin pick: the lowest valid index at or above rr_ptr wins; if none
  // exists the search wraps and the lowest valid index overall wins. Scanning
  // downward lets the last hit be the lowest index.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(i);
        end
      end
    end
  end

  assign w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = rst_n && (state_q == C_IDLE) && w_lo_found &&
                     (w_win_idx == ID_W'(i));
    end
  end

  assign w_accept     = |(req_valid & req_ready);
  assign w_frame_last = baud_clk_en && (cnt_q == C_FRAME_LAST);
  assign w_gap_last   = baud_clk_en && (cnt_q == C_GAP_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:   if (w_accept) state_d = C_LAUNCH;
      C_LAUNCH: state_d = C_FRAME;
      C_FRAME:  if (w_frame_last) state_d = C_HAS_GAP ? C_GAP : C_IDLE;
      C_GAP:    if (w_gap_last) state_d = C_IDLE;
      default:  state_d = C_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
    frame_done_d = 1'b0;
    // Registered start: high exactly while the state is LAUNCH.
    tx_start_d   = (state_d == C_LAUNCH);
    case (state_q)
      C_IDLE: begin
        if (w_accept) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (w_win_idx == ID_W'(i)) tx_data_d = req_data[8*i +: 8];
          end
          grant_d  = w_win_idx;
          rr_ptr_d = (w_win_idx == C_LAST_ID) ? '0 : w_win_idx + 1'b1;
          cnt_d    = '0;
        end
      end
      // The UART is still idle here; a baud pulse now is not part of the frame.
      C_LAUNCH: cnt_d = cnt_q;
      C_FRAME: begin
        if (w_frame_last) begin
          cnt_d        = '0;
          frame_done_d = 1'b1;
        end else if (baud_clk_en) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      C_GAP: begin
        if (w_gap_last) begin
          cnt_d = '0;
        end else if (baud_clk_en) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      grant_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      grant_q      <= grant_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_start_send = tx_start_q;
  assign grant_id      = grant_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q != C_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_scheduler
//  Purpose  : Self-checking bench for uart_tx_scheduler. Two instances share
//             the stimulus: one with an 11-tick frame and no gap, one with a
//             3-tick frame and a 2-tick gap. A reference model describes each
//             frame as "launch cycle, then a budget of baud ticks".
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int F0 = 11;
  localparam int G0 = 0;
  localparam int F1 = 3;
  localparam int G1 = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             baud;
  logic [N-1:0]     valid;
  logic [8*N-1:0]   data;

  logic [N-1:0] rdy0, rdy1;
  logic [7:0]   txd0, txd1;
  logic         st0, st1, bsy0, bsy1, fd0, fd1;
  logic [1:0]   gid0, gid1;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N_REQ(N), .ID_W(2), .FRAME_TICKS(F0), .GAP_TICKS(G0)) dut0 (
    .clk(clk), .rst_n(rst_n), .baud_clk_en(baud), .req_valid(valid), .req_data(data),
    .req_ready(rdy0), .tx_data(txd0), .tx_start_send(st0), .grant_id(gid0),
    .busy(bsy0), .frame_done(fd0));

  uart_tx_scheduler #(.N_REQ(N), .ID_W(2), .FRAME_TICKS(F1), .GAP_TICKS(G1)) dut1 (
    .clk(clk), .rst_n(rst_n), .baud_clk_en(baud), .req_valid(valid), .req_data(data),
    .req_ready(rdy1), .tx_data(txd1), .tx_start_send(st1), .grant_id(gid1),
    .busy(bsy1), .frame_done(fd1));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // launch : the cycle after an accept (start pulse visible)
  // left   : baud ticks still owed for frame + gap; zero and !launch means idle
  typedef struct {
    bit         launch;
    int         left;
    int         rr;
    int         grant;
    logic [7:0] txd;
    bit         fd;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mrst();
    mdl_t m;
    m.launch = 0; m.left = 0; m.rr = 0; m.grant = 0; m.txd = 8'h00; m.fd = 0;
    return m;
  endfunction

  function automatic int pick(int rr, logic [N-1:0] v);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (rr + k) % N;
      if (v[2'(i)]) return i;
    end
    return -1;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [N-1:0] v, logic [8*N-1:0] d,
                                 bit b, int f, int g);
    mdl_t n;
    int   w;
    n    = m;
    n.fd = 0;
    if (!m.launch && m.left == 0) begin
      w = pick(m.rr, v);
      if (w >= 0) begin
        n.txd    = 8'(d >> (8 * w));
        n.grant  = w;
        n.rr     = (w + 1) % N;
        n.launch = 1;
        n.left   = f + g;
      end
    end else if (m.launch) begin
      n.launch = 0;
    end else if (b) begin
      n.left = m.left - 1;
      n.fd   = (n.left == g);
    end
    return n;
  endfunction

  function automatic logic [N-1:0] exp_ready(mdl_t m, logic [N-1:0] v, logic rn);
    logic [N-1:0] r;
    int           w;
    r = '0;
    if (rn && !m.launch && m.left == 0) begin
      w = pick(m.rr, v);
      if (w >= 0) r[2'(w)] = 1'b1;
    end
    return r;
  endfunction

  task automatic check_dut(string nm, mdl_t m, logic [N-1:0] r, logic [7:0] t,
                           logic s, logic [1:0] g, logic b, logic f);
    cmp({nm, ".req_ready"},     32'(r), 32'(exp_ready(m, valid, rst_n)));
    cmp({nm, ".tx_data"},       32'(t), 32'(m.txd));
    cmp({nm, ".tx_start_send"}, 32'(s), 32'(m.launch));
    cmp({nm, ".grant_id"},      32'(g), 32'(m.grant));
    cmp({nm, ".busy"},          32'(b), 32'(m.launch || m.left != 0));
    cmp({nm, ".frame_done"},    32'(f), 32'(m.fd));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m0 = mrst();
      m1 = mrst();
    end
    check_dut("d0", m0, rdy0, txd0, st0, gid0, bsy0, fd0);
    check_dut("d1", m1, rdy1, txd1, st1, gid1, bsy1, fd1);
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m0 = mstep(m0, valid, data, baud, F0, G0);
      m1 = mstep(m1, valid, data, baud, F1, G1);
    end
  end

  // ---------------- directed vector table (instance 0) ----------------
  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    bit          b;
    logic [3:0]  er;
    logic [7:0]  etx;
    bit          est;
    logic [1:0]  eg;
    bit          eb;
    bit          efd;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [7:0] db[N];
  logic       vb[N];
  int         got[5];
  int         ng, nfd;

  initial begin
    m0 = mrst();
    m1 = mrst();
    rst_n = 1'b0; baud = 1'b0; valid = '0; data = '0;

    tbl[0]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 32'h00A5_0000, 1'b0, 4'b0100, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 32'h00A5_0000, 1'b1, 4'b0000, 8'hA5, 1'b1, 2'd2, 1'b1, 1'b0};
    for (int r = 3; r <= 13; r++)
      tbl[r] = '{4'b0000, 32'h00A5_0000, 1'b1, 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[14] = '{4'b0010, 32'h0000_3C00, 1'b0, 4'b0010, 8'hA5, 1'b0, 2'd2, 1'b0, 1'b1};
    tbl[15] = '{4'b0000, 32'h0000_3C00, 1'b0, 4'b0000, 8'h3C, 1'b1, 2'd1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request, launch-cycle tick, 11 ticks, back-to-back accept.
    for (int r = 0; r < 16; r++) begin
      valid = tbl[r].v; data = tbl[r].d; baud = tbl[r].b;
      @(negedge clk);
      cmp($sformatf("tbl[%0d].req_ready", r),  32'(rdy0), 32'(tbl[r].er));
      cmp($sformatf("tbl[%0d].tx_data", r),    32'(txd0), 32'(tbl[r].etx));
      cmp($sformatf("tbl[%0d].start", r),      32'(st0),  32'(tbl[r].est));
      cmp($sformatf("tbl[%0d].grant_id", r),   32'(gid0), 32'(tbl[r].eg));
      cmp($sformatf("tbl[%0d].busy", r),       32'(bsy0), 32'(tbl[r].eb));
      cmp($sformatf("tbl[%0d].frame_done", r), 32'(fd0),  32'(tbl[r].efd));
      step();
    end

    // Reset mid-frame: after 5 ticks everything returns to reset values.
    valid = '0; baud = 1'b1;
    repeat (5) step();
    rst_n = 1'b0; baud = 1'b0; valid = 4'b0010; data = 32'h0000_5A00;
    @(negedge clk);
    cmp("rst.busy",       32'(bsy0), 32'd0);
    cmp("rst.tx_data",    32'(txd0), 32'd0);
    cmp("rst.grant_id",   32'(gid0), 32'd0);
    cmp("rst.start",      32'(st0),  32'd0);
    cmp("rst.frame_done", 32'(fd0),  32'd0);
    cmp("rst.req_ready",  32'(rdy0), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    cmp("post_rst.req_ready", 32'(rdy0), 32'b0010);
    step();
    valid = '0;
    @(negedge clk);
    cmp("post_rst.start",    32'(st0),  32'd1);
    cmp("post_rst.grant_id", 32'(gid0), 32'd1);
    cmp("post_rst.tx_data",  32'(txd0), 32'h5A);
    step();

    // Round-robin with all requesters pending.
    pulse_rst();
    valid = 4'b1111; data = 32'h4433_2211; baud = 1'b1;
    ng = 0; nfd = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (fd0) nfd++;
      if (st0) begin
        got[ng] = int'(gid0);
        ng++;
      end
      if (ng == 5) break;
      step();
    end
    step();
    cmp("rr.grant_count", 32'(ng), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < ng) cmp($sformatf("rr.grant[%0d]", k), 32'(got[k]), 32'(k % 4));
    cmp("rr.frame_done_count", 32'(nfd), 32'd4);

    // Request raised during a frame; ticks every other cycle.
    valid = '0; baud = 1'b0;
    pulse_rst();
    valid = 4'b0001; data = 32'h0000_7711;
    step();
    valid = '0; baud = 1'b1;   // LAUNCH cycle pulse, must be ignored
    step();
    for (int t = 1; t <= 11; t++) begin
      baud = 1'b0;
      if (t == 5) valid = 4'b0010;
      @(negedge clk);
      if (t >= 5) cmp($sformatf("mid.ready_hold[%0d]", t), 32'(rdy0), 32'd0);
      step();
      baud = 1'b1;
      @(negedge clk);
      if (t >= 5) cmp($sformatf("mid.ready_tick[%0d]", t), 32'(rdy0), 32'd0);
      cmp($sformatf("mid.no_early_done[%0d]", t), 32'(fd0), 32'd0);
      step();
    end
    baud = 1'b0;
    @(negedge clk);
    cmp("mid.ready_after",  32'(rdy0), 32'b0010);
    cmp("mid.frame_done",   32'(fd0),  32'd1);
    step();
    valid = '0;
    @(negedge clk);
    cmp("mid.start_T+2",    32'(st0),  32'd1);
    cmp("mid.grant_id",     32'(gid0), 32'd1);
    cmp("mid.tx_data",      32'(txd0), 32'h77);
    step();

    // Gap on instance 1: second accept only 2 baud ticks after frame_done.
    pulse_rst();
    valid = 4'b0011; data = 32'h0000_BBAA; baud = 1'b1;
    repeat (5) step();
    @(negedge clk);
    cmp("gap.frame_done", 32'(fd1),  32'd1);
    cmp("gap.ready_g0",   32'(rdy1), 32'd0);
    step();
    @(negedge clk);
    cmp("gap.ready_g1",   32'(rdy1), 32'd0);
    step();
    @(negedge clk);
    cmp("gap.ready_idle", 32'(rdy1), 32'b0010);
    cmp("gap.busy_idle",  32'(bsy1), 32'd0);
    step();
    valid = '0;
    @(negedge clk);
    cmp("gap.start",      32'(st1),  32'd1);
    cmp("gap.grant_id",   32'(gid1), 32'd1);
    cmp("gap.tx_data",    32'(txd1), 32'hBB);
    step();

    // Random traffic checked by the model every cycle.
    valid = '0; baud = 1'b0;
    pulse_rst();
    for (int i = 0; i < N; i++) begin
      db[i] = 8'h00;
      vb[i] = 1'b0;
    end
    for (int c = 0; c < 4000; c++) begin
      baud = (c >= 3000) ? 1'b1 : ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        if (!vb[i]) begin
          db[i] = 8'($urandom);
          vb[i] = ($urandom_range(0, 3) == 0);
        end else begin
          vb[i] = ($urandom_range(0, 7) != 0);
        end
      end
      valid = {vb[3], vb[2], vb[1], vb[0]};
      data  = {db[3], db[2], db[1], db[0]};
      if (c == 2000) begin
        pulse_rst();
      end else begin
        step();
      end
    end
    valid = '0;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
